// File: rtl/stream_skid_buf.sv
// Two-entry output buffer for the block reader stream. Head entry drives the
// outputs directly, so data and last stay put while the consumer stalls.
module stream_skid_buf #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] head_p0;
  logic [W-1:0] tail_p0;
  logic [1:0]   cnt_p0;
  logic         pop;

  assign pop       = (cnt_p0 != 2'd0) & out_ready;
  assign out_valid = (cnt_p0 != 2'd0);
  assign out_data  = head_p0;
  assign count     = cnt_p0;

  // Writer never pushes into a full buffer without a same-cycle pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_p0 <= '0;
      tail_p0 <= '0;
      cnt_p0  <= 2'd0;
    end else begin
      case ({in_valid, pop})
        2'b10: begin
          if (cnt_p0 == 2'd0) head_p0 <= in_data;
          else                tail_p0 <= in_data;
          cnt_p0 <= cnt_p0 + 2'd1;
        end
        2'b01: begin
          head_p0 <= tail_p0;
          cnt_p0  <= cnt_p0 - 2'd1;
        end
        2'b11: begin
          if (cnt_p0 == 2'd2) begin
            head_p0 <= tail_p0;
            tail_p0 <= in_data;
          end else begin
            head_p0 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ram_block_reader.sv
// Streams a contiguous block out of an external 1-clk-latency RAM, wrapping
// the address modulo DEPTH, with flow control into a 2-entry output buffer.
module ram_block_reader #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    start_addr,
  input  logic [AW:0]      length,
  output logic [AW-1:0]    raddr,
  input  logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [AW-1:0] ADDR_ONE = 1;
  localparam logic [AW:0]   LEN_ONE  = 1;

  state_t         state;
  logic [AW:0]    remaining;
  logic           vld_p1;
  logic           last_p1;
  logic [1:0]     buf_cnt;
  logic           buf_valid;
  logic [WIDTH:0] buf_out;
  logic           pop;
  logic [2:0]     occ;
  logic           issue;

  assign pop   = buf_valid & out_ready;
  assign occ   = {1'b0, buf_cnt} + {2'b00, vld_p1} - {2'b00, pop};
  assign issue = (state == RUN) && (occ < 3'd2);

  // Issue stage: raddr is presented to the RAM; vld_p1 marks data due next clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      raddr     <= '0;
      remaining <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done    <= 1'b0;
      vld_p1  <= issue;
      last_p1 <= issue && (remaining == '0);
      case (state)
        IDLE: begin
          if (start && (length != '0)) begin
            state     <= RUN;
            raddr     <= start_addr;
            remaining <= length - LEN_ONE;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (issue) begin
            if (remaining == '0) begin
              state <= DRAIN;
            end else begin
              raddr     <= raddr + ADDR_ONE;
              remaining <= remaining - LEN_ONE;
            end
          end
        end
        DRAIN: begin
          if (pop && buf_out[WIDTH]) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Capture stage: RAM data lands in the buffer together with its last flag.
  stream_skid_buf #(
    .W(WIDTH + 1)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (vld_p1),
    .in_data  ({last_p1, rdata}),
    .out_valid(buf_valid),
    .out_ready(out_ready),
    .out_data (buf_out),
    .count    (buf_cnt)
  );

  assign out_valid = buf_valid;
  assign out_data  = buf_out[WIDTH-1:0];
  assign out_last  = buf_valid & buf_out[WIDTH];

endmodule

// File: tb/tb_ram_block_reader.sv
// Directed bench for ram_block_reader with a 16-word RAM holding i+A0.
module tb_ram_block_reader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [AW-1:0]    start_addr = '0;
  logic [AW:0]      length = '0;
  logic [AW-1:0]    raddr;
  logic [WIDTH-1:0] rdata;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             out_last;
  logic             busy;
  logic             done;

  logic [7:0] mem [DEPTH];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int stall_viol = 0;
  logic [8:0] got_q [$];
  logic       prev_stall = 1'b0;
  logic [8:0] prev_word = '0;

  ram_block_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_addr(start_addr),
    .length    (length),
    .raddr     (raddr),
    .rdata     (rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < DEPTH; i++) mem[i] = 8'hA0 + 8'(i);

  always @(posedge clk) rdata <= mem[raddr];

  // Stream monitor on the inactive edge: records handshakes, done pulses and
  // any change of the presented word during a stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!out_valid || {out_last, out_data} !== prev_word)) stall_viol++;
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      if (done) done_cnt++;
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input logic [AW-1:0] a, input logic [AW:0] l);
    start_addr = a;
    length     = l;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({raddr, out_valid, out_last, out_data, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_values got raddr=%h valid=%b last=%b data=%h busy=%b done=%b expected all zero",
               raddr, out_valid, out_last, out_data, busy, done);
    end
    rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got busy=%b valid=%b done=%b expected 0 0 0", busy, out_valid, done);
    end
  endtask

  task automatic test_basic();
    logic [7:0] exp_d [4];
    exp_d = '{8'hA3, 8'hA4, 8'hA5, 8'hA6};
    out_ready = 1'b1;
    got_q.delete();
    start_block(4'd3, 5'd4);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got %b expected 1", busy);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency got valid=%b one clk after accept, expected 0", out_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_last !== (i == 3)) begin
        errors++;
        $display("FAIL basic_word%0d got valid=%b data=%h last=%b expected valid=1 data=%h last=%b",
                 i, out_valid, out_data, out_last, exp_d[i], (i == 3));
      end
    end
    step();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_done got done=%b busy=%b valid=%b expected 1 0 0", done, busy, out_valid);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse got done=%b expected 0", done);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [7:0] exp_d [4];
    logic [8:0] e;
    exp_d = '{8'hAE, 8'hAF, 8'hA0, 8'hA1};
    out_ready = 1'b1;
    got_q.delete();
    start_block(4'd14, 5'd4);
    wait_done(30, ok);
    step();
    checks++;
    if (!ok || got_q.size() != 4) begin
      errors++;
      $display("FAIL wrap_count got done_seen=%b words=%0d expected 1 4", ok, got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      e = {(i == 3), exp_d[i]};
      checks++;
      if (got_q[i] !== e) begin
        errors++;
        $display("FAIL wrap_word%0d got %h expected %h", i, got_q[i], e);
      end
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int sv0;
    logic [8:0] e;
    got_q.delete();
    sv0 = stall_viol;
    out_ready = 1'b1;
    start_block(4'd0, 5'd16);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      step();
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (!ok || got_q.size() != 16) begin
      errors++;
      $display("FAIL bp_count got done_seen=%b words=%0d expected 1 16", ok, got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 16; i++) begin
      e = {(i == 15), 8'hA0 + 8'(i)};
      checks++;
      if (got_q[i] !== e) begin
        errors++;
        $display("FAIL bp_word%0d got %h expected %h", i, got_q[i], e);
      end
    end
    checks++;
    if (stall_viol !== sv0) begin
      errors++;
      $display("FAIL bp_stall_stable got %0d unstable stalls expected 0", stall_viol - sv0);
    end
  endtask

  task automatic test_ignore();
    bit ok;
    int dc0;
    logic [8:0] e;
    out_ready = 1'b1;
    got_q.delete();
    dc0 = done_cnt;
    start_addr = 4'd2;
    length     = 5'd0;
    start      = 1'b1;
    repeat (3) step();
    start = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || done_cnt != dc0 || got_q.size() != 0) begin
      errors++;
      $display("FAIL ignore_len0 got busy=%b valid=%b dones=%0d words=%0d expected 0 0 0 0",
               busy, out_valid, done_cnt - dc0, got_q.size());
    end
    start_block(4'd3, 5'd4);
    step();
    start_addr = 4'd9;
    length     = 5'd2;
    start      = 1'b1;
    step();
    step();
    start = 1'b0;
    wait_done(30, ok);
    repeat (4) step();
    checks++;
    if (!ok || got_q.size() != 4 || done_cnt != dc0 + 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_busy got done_seen=%b words=%0d dones=%0d busy=%b expected 1 4 1 0",
               ok, got_q.size(), done_cnt - dc0, busy);
    end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      e = {(i == 3), 8'hA3 + 8'(i)};
      checks++;
      if (got_q[i] !== e) begin
        errors++;
        $display("FAIL ignore_word%0d got %h expected %h", i, got_q[i], e);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int dc0;
    logic [8:0] exp_w [3];
    exp_w = '{9'h0A1, 9'h1A2, 9'h1A8};
    out_ready = 1'b1;
    got_q.delete();
    dc0 = done_cnt;
    start_block(4'd1, 5'd2);
    wait_done(20, ok);
    start_block(4'd8, 5'd1);
    checks++;
    if (!ok || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got done_seen=%b busy=%b expected 1 1", ok, busy);
    end
    wait_done(20, ok);
    step();
    checks++;
    if (!ok || got_q.size() != 3 || done_cnt != dc0 + 2) begin
      errors++;
      $display("FAIL b2b_count got done_seen=%b words=%0d dones=%0d expected 1 3 2",
               ok, got_q.size(), done_cnt - dc0);
    end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      checks++;
      if (got_q[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL b2b_word%0d got %h expected %h", i, got_q[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_ready = 1'b1;
    got_q.delete();
    start_block(4'd0, 5'd8);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (got_q.size() >= 2) begin
        ok = 1'b1;
        break;
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (!ok || {raddr, out_valid, out_last, out_data, busy, done} !== '0) begin
      errors++;
      $display("FAIL rstmid_values got reached=%b raddr=%h valid=%b last=%b data=%h busy=%b done=%b expected 1 and all zero",
               ok, raddr, out_valid, out_last, out_data, busy, done);
    end
    step();
    step();
    rst_n = 1'b1;
    repeat (10) step();
    checks++;
    if (got_q.size() != 2 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_quiet got words=%0d valid=%b busy=%b expected 2 0 0",
               got_q.size(), out_valid, busy);
    end
    got_q.delete();
    start_block(4'd5, 5'd1);
    wait_done(20, ok);
    step();
    checks++;
    if (!ok || got_q.size() != 1) begin
      errors++;
      $display("FAIL rstmid_restart_count got done_seen=%b words=%0d expected 1 1", ok, got_q.size());
    end else if (got_q[0] !== 9'h1A5) begin
      errors++;
      $display("FAIL rstmid_restart_word got %h expected 1a5", got_q[0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
